top: RTL and testbench

Single-cycle RV32I processor core with on-chip instruction and data memories. Every instruction is fetched, decoded, executed and retired in one clock cycle. The core sits at the top of the processor design and has only a clock and reset. Programs are preloaded into instruction memory by the bench, and results are checked through hierarchical access to the register file.

---
 rtl/top.sv | 279 +++++++++++++++++++++++++++
 tb/tb_top.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Single-cycle RV32I core with instruction memory, register file and data memory.
// Optional `TOP_BYTE_LS_EN adds LB/LH/LBU/LHU/SB/SH; otherwise those encodings are NOPs.

module imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign rdata = memory[raddr];
endmodule

module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && wa != 5'd0) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module top #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, pc, pc_plus4, instruction;
  logic [31:0] rs1_data, rs2_data, imm, op1_mux_out, op2_mux_out;
  logic [31:0] alu_result, write_data, load_data, dmem_rdata;
  logic [31:0] store_mask, store_data;
  logic [3:0]  alu_op;
  logic        zero_flag, reg_write, alu_src, mem_to_reg, branch, jump;
  logic        mem_write, op1_pc, is_jalr, branch_taken;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [DW-1:0] dmem_idx;
  logic [31:0] dmem_q [0:DMEM_WORDS-1];
  logic        unused_zero;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7   = instruction[31:25];

  imem #(.WORDS(IMEM_WORDS)) instruction_mem (
    .clk(clk), .we(1'b0), .waddr('0), .wdata(32'd0),
    .raddr(pc_q[IW+1:2]), .rdata(instruction)
  );

  regfile registers (
    .clk(clk), .reset(reset), .we(reg_write),
    .ra1(instruction[19:15]), .ra2(instruction[24:20]), .wa(instruction[11:7]),
    .wd(write_data), .rd1(rs1_data), .rd2(rs2_data)
  );

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? 4'd1 : 4'd0;
      3'b001:  alu_sel = 4'd2;
      3'b010:  alu_sel = 4'd3;
      3'b011:  alu_sel = 4'd4;
      3'b100:  alu_sel = 4'd5;
      3'b101:  alu_sel = alt ? 4'd7 : 4'd6;
      3'b110:  alu_sel = 4'd8;
      default: alu_sel = 4'd9;
    endcase
  endfunction

  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_write  = 1'b0;
    op1_pc     = 1'b0;
    is_jalr    = 1'b0;
    alu_op     = 4'd0;
    imm        = {{20{instruction[31]}}, instruction[31:20]};
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          reg_write = 1'b1;
          alu_op    = alu_sel(funct3, funct7[5]);
        end
      end
      7'b0010011: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'h00 ||
            (funct3 == 3'b101 && funct7 == 7'h20)) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = alu_sel(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      7'b0000011: begin
`ifdef TOP_BYTE_LS_EN
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
            funct3 == 3'b100 || funct3 == 3'b101) begin
`else
        if (funct3 == 3'b010) begin
`endif
          reg_write  = 1'b1;
          alu_src    = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      7'b0100011: begin
        imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
`ifdef TOP_BYTE_LS_EN
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
`else
        if (funct3 == 3'b010) begin
`endif
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
      end
      7'b1100011: begin
        imm = {{20{instruction[31]}}, instruction[7], instruction[30:25],
               instruction[11:8], 1'b0};
        branch = (funct3 != 3'b010 && funct3 != 3'b011);
        alu_op = 4'd1;
      end
      7'b0110111: begin
        imm       = {instruction[31:12], 12'd0};
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 4'd10;
      end
      7'b0010111: begin
        imm       = {instruction[31:12], 12'd0};
        reg_write = 1'b1;
        alu_src   = 1'b1;
        op1_pc    = 1'b1;
      end
      7'b1101111: begin
        imm       = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
        reg_write = 1'b1;
        alu_src   = 1'b1;
        op1_pc    = 1'b1;
        jump      = 1'b1;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          jump      = 1'b1;
          is_jalr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign op1_mux_out = op1_pc ? pc_q : rs1_data;
  assign op2_mux_out = alu_src ? imm : rs2_data;

  always_comb begin
    case (alu_op)
      4'd0:    alu_result = op1_mux_out + op2_mux_out;
      4'd1:    alu_result = op1_mux_out - op2_mux_out;
      4'd2:    alu_result = op1_mux_out << op2_mux_out[4:0];
      4'd3:    alu_result = {31'd0, $signed(op1_mux_out) < $signed(op2_mux_out)};
      4'd4:    alu_result = {31'd0, op1_mux_out < op2_mux_out};
      4'd5:    alu_result = op1_mux_out ^ op2_mux_out;
      4'd6:    alu_result = op1_mux_out >> op2_mux_out[4:0];
      4'd7:    alu_result = $unsigned($signed(op1_mux_out) >>> op2_mux_out[4:0]);
      4'd8:    alu_result = op1_mux_out | op2_mux_out;
      4'd9:    alu_result = op1_mux_out & op2_mux_out;
      default: alu_result = op2_mux_out;
    endcase
  end

  assign zero_flag   = (alu_result == 32'd0);
  assign unused_zero = zero_flag;

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data < rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  // Branch target uses its own adder because op1 carries rs1 for branches.
  always_comb begin
    if (jump)                        pc_d = is_jalr ? (alu_result & ~32'd1) : alu_result;
    else if (branch && branch_taken) pc_d = pc_q + imm;
    else                             pc_d = pc_plus4;
  end

  assign dmem_idx   = alu_result[DW+1:2];
  assign dmem_rdata = dmem_q[dmem_idx];

`ifdef TOP_BYTE_LS_EN
  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{dmem_rdata[{alu_result[1:0], 3'b111}]}},
                            dmem_rdata[{alu_result[1:0], 3'b000} +: 8]};
      3'b001:  load_data = {{16{dmem_rdata[{alu_result[1], 4'b1111}]}},
                            dmem_rdata[{alu_result[1], 4'b0000} +: 16]};
      3'b100:  load_data = {24'd0, dmem_rdata[{alu_result[1:0], 3'b000} +: 8]};
      3'b101:  load_data = {16'd0, dmem_rdata[{alu_result[1], 4'b0000} +: 16]};
      default: load_data = dmem_rdata;
    endcase
    case (funct3)
      3'b000: begin
        store_mask = 32'h0000_00FF << {alu_result[1:0], 3'b000};
        store_data = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        store_mask = alu_result[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        store_data = {2{rs2_data[15:0]}};
      end
      default: begin
        store_mask = 32'hFFFF_FFFF;
        store_data = rs2_data;
      end
    endcase
  end
`else
  assign load_data  = dmem_rdata;
  assign store_mask = 32'hFFFF_FFFF;
  assign store_data = rs2_data;
`endif

  assign write_data = mem_to_reg ? load_data : (jump ? pc_plus4 : alu_result);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (mem_write) begin
      dmem_q[dmem_idx] <= (dmem_q[dmem_idx] & ~store_mask) | (store_data & store_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end
endmodule

// File: tb/tb_top.sv
// Directed bench for the single-cycle RV32I core: loads small programs into
// instruction memory and checks register/pc state against hand-computed values.

module tb_top;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  top dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          prog;
    int          rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3, logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                        logic [31:0] rd, logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1,
                                        logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [31:0] op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] addi(logic [31:0] rd, logic [31:0] rs1, logic [31:0] imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_prog(int id);
    logic [31:0] p[$];
    case (id)
      0: p = '{addi(1,0,5), addi(2,0,3), enc_r(0,2,1,0,3), enc_r(32,2,1,0,4),
               enc_r(0,2,1,7,5), enc_r(0,2,1,6,6), enc_r(0,2,1,4,7), enc_r(0,2,1,2,8),
               enc_r(0,2,1,1,9), enc_r(0,1,2,3,10), enc_r(0,2,1,5,11), enc_r(32,2,0,0,12),
               enc_r(32,1,12,5,13), enc_r(0,1,12,5,14), enc_r(0,1,12,3,15), enc_r(0,1,12,2,16)};
      1: p = '{addi(1,0,-1), enc_i(0,1,2,2,7'h13), enc_i(1,1,3,3,7'h13),
               enc_i(32'h404,1,5,4,7'h13), enc_i(28,1,5,5,7'h13), addi(0,0,7),
               enc_i(32'h0F0,1,4,6,7'h13), enc_i(32'h123,0,6,7,7'h13),
               enc_i(-16,1,7,8,7'h13), enc_i(31,1,1,9,7'h13)};
      2: p = '{addi(1,0,32'h55), enc_s(8,1,0,2), enc_i(8,0,2,2,3), addi(3,0,32'h3FF),
               enc_s(1032,3,0,2), enc_i(8,0,2,4,3), enc_i(9,0,2,5,3), 32'h0000_0073,
               32'h0000_000F, enc_i(8,0,0,6,3), 32'h0010_0073, enc_i(4,0,2,7,3),
               enc_r(1,1,1,0,8)};
      3: p = '{addi(1,0,1), addi(2,0,1), enc_b(8,2,1,0), addi(3,0,9), enc_b(8,2,1,1),
               addi(4,0,4), addi(5,0,-1), enc_b(8,1,5,4), addi(6,0,1), enc_b(8,1,5,6),
               addi(7,0,7), enc_b(8,5,1,5), addi(8,0,8), enc_b(8,5,1,7), addi(9,0,9)};
      4: p = '{enc_u(32'h12345,1,7'h37), enc_u(1,2,7'h17), enc_j(8,3), addi(5,0,5),
               enc_i(0,3,0,4,7'h67)};
      default: p = '{addi(1,0,32'h80), enc_s(5,1,0,0), enc_i(5,0,0,2,3), enc_i(5,0,4,3,3),
               enc_i(4,0,2,4,3), addi(5,0,-2), enc_s(6,5,0,1), enc_i(4,0,2,6,3),
               enc_i(6,0,1,7,3), enc_i(6,0,5,8,3)};
    endcase
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.instruction_mem.memory[i] = 32'h0000_0013;
    for (int i = 0; i < p.size(); i++) dut.instruction_mem.memory[i] = p[i];
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cur;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;

    vecs.push_back('{0, 3, 32'd8, "add"});
    vecs.push_back('{0, 4, 32'd2, "sub"});
    vecs.push_back('{0, 5, 32'd1, "and"});
    vecs.push_back('{0, 6, 32'd7, "or"});
    vecs.push_back('{0, 7, 32'd6, "xor"});
    vecs.push_back('{0, 8, 32'd0, "slt"});
    vecs.push_back('{0, 9, 32'h28, "sll"});
    vecs.push_back('{0, 10, 32'd1, "sltu"});
    vecs.push_back('{0, 11, 32'd0, "srl"});
    vecs.push_back('{0, 12, 32'hFFFF_FFFD, "sub_neg"});
    vecs.push_back('{0, 13, 32'hFFFF_FFFF, "sra"});
    vecs.push_back('{0, 14, 32'h07FF_FFFF, "srl_neg"});
    vecs.push_back('{0, 15, 32'd0, "sltu_big"});
    vecs.push_back('{0, 16, 32'd1, "slt_neg"});
    vecs.push_back('{1, 1, 32'hFFFF_FFFF, "addi_m1"});
    vecs.push_back('{1, 2, 32'd1, "slti"});
    vecs.push_back('{1, 3, 32'd0, "sltiu"});
    vecs.push_back('{1, 4, 32'hFFFF_FFFF, "srai"});
    vecs.push_back('{1, 5, 32'h0000_000F, "srli"});
    vecs.push_back('{1, 0, 32'd0, "x0_write"});
    vecs.push_back('{1, 6, 32'hFFFF_FF0F, "xori"});
    vecs.push_back('{1, 7, 32'h0000_0123, "ori"});
    vecs.push_back('{1, 8, 32'hFFFF_FFF0, "andi"});
    vecs.push_back('{1, 9, 32'h8000_0000, "slli"});
    vecs.push_back('{2, 2, 32'h55, "lw"});
    vecs.push_back('{2, 4, 32'h3FF, "sw_wrap"});
    vecs.push_back('{2, 5, 32'h3FF, "lw_misalign"});
    vecs.push_back('{2, 7, 32'd0, "lw_cleared"});
    vecs.push_back('{2, 8, 32'd0, "mul_nop"});
`ifdef TOP_BYTE_LS_EN
    vecs.push_back('{2, 6, 32'hFFFF_FFFF, "lb_word"});
`else
    vecs.push_back('{2, 6, 32'd0, "lb_nop"});
`endif
    vecs.push_back('{3, 3, 32'd0, "beq_skip"});
    vecs.push_back('{3, 4, 32'd4, "bne_fall"});
    vecs.push_back('{3, 6, 32'd0, "blt_skip"});
    vecs.push_back('{3, 7, 32'd7, "bltu_fall"});
    vecs.push_back('{3, 8, 32'd0, "bge_skip"});
    vecs.push_back('{3, 9, 32'd9, "bgeu_fall"});
    vecs.push_back('{4, 1, 32'h1234_5000, "lui"});
    vecs.push_back('{4, 2, 32'h0000_1004, "auipc"});
    vecs.push_back('{4, 3, 32'h0000_000C, "jal_link"});
    vecs.push_back('{4, 4, 32'h0000_0014, "jalr_link"});
    vecs.push_back('{4, 5, 32'd5, "jalr_target"});
    vecs.push_back('{5, 5, 32'hFFFF_FFFE, "addi_m2"});
`ifdef TOP_BYTE_LS_EN
    vecs.push_back('{5, 2, 32'hFFFF_FF80, "lb"});
    vecs.push_back('{5, 3, 32'h0000_0080, "lbu"});
    vecs.push_back('{5, 4, 32'h0000_8000, "sb_word"});
    vecs.push_back('{5, 6, 32'hFFFE_8000, "sh_word"});
    vecs.push_back('{5, 7, 32'hFFFF_FFFE, "lh"});
    vecs.push_back('{5, 8, 32'h0000_FFFE, "lhu"});
`else
    vecs.push_back('{5, 2, 32'd0, "lb_nop"});
    vecs.push_back('{5, 3, 32'd0, "lbu_nop"});
    vecs.push_back('{5, 4, 32'd0, "sb_nop"});
    vecs.push_back('{5, 6, 32'd0, "sh_nop"});
    vecs.push_back('{5, 7, 32'd0, "lh_nop"});
    vecs.push_back('{5, 8, 32'd0, "lhu_nop"});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", dut.pc, 32'd0);
    check("rst_x1", dut.registers.registers[1], 32'd0);
    check("rst_x31", dut.registers.registers[31], 32'd0);

    cur = -1;
    foreach (vecs[k]) begin
      if (vecs[k].prog != cur) begin
        cur = vecs[k].prog;
        load_prog(cur);
        run(30);
      end
      check(vecs[k].name, dut.registers.registers[vecs[k].rd], vecs[k].exp);
    end

    // Branch pc trace: beq at 8 skips 12
    load_prog(3);
    check("br_pc0", dut.pc, 32'd0);
    run(1); check("br_pc1", dut.pc, 32'd4);
    run(1); check("br_pc2", dut.pc, 32'd8);
    run(1); check("br_pc3", dut.pc, 32'd16);
    run(1); check("br_pc4", dut.pc, 32'd20);

    // U/J pc trace: jal 8->16, jalr back to 12
    load_prog(4);
    run(3); check("jal_pc", dut.pc, 32'd16);
    run(1); check("jalr_pc", dut.pc, 32'd12);

    // Mid-run asynchronous reset
    load_prog(2);
    run(5);
    check("pre_rst_x2", dut.registers.registers[2], 32'h55);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pc", dut.pc, 32'd0);
    check("mid_rst_x1", dut.registers.registers[1], 32'd0);
    check("mid_rst_x2", dut.registers.registers[2], 32'd0);
    run(2);
    check("held_rst_pc", dut.pc, 32'd0);
    reset = 1'b0;
    run(1); check("restart_pc", dut.pc, 32'd4);
    check("restart_x1", dut.registers.registers[1], 32'h55);
    run(2); check("restart_x2", dut.registers.registers[2], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
